// File: rtl/triangle_scan_ctrl.sv
// triangle_scan_ctrl: bounding-box raster scan of one triangle at a time.
// A single edge-function evaluator is time-shared: the SETUP cycle uses it for
// the signed area, and EVAL0/1/2 use it for the three edges of the current pixel.
// Optional build macro TRI_SCAN_STATS_EN adds stat_tested / stat_emitted counters.
module triangle_scan_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter bit EDGE_INCL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] v1x,
  input  logic [10:0] v1y,
  input  logic [10:0] v2x,
  input  logic [10:0] v2y,
  input  logic [10:0] v3x,
  input  logic [10:0] v3y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_x,
  output logic [10:0] out_y,
  output logic        busy,
  output logic        done
`ifdef TRI_SCAN_STATS_EN
  ,
  output logic [21:0] stat_tested,
  output logic [21:0] stat_emitted
`endif
);

  localparam logic [10:0] XLIM = 11'(SCREEN_W - 1);
  localparam logic [10:0] YLIM = 11'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, EVAL0, EVAL1, EVAL2, EMIT, STEP, DONE
  } state_t;

  state_t state, state_nx;

  logic [10:0] x1, y1, x2, y2, x3, y3;
  logic [10:0] cx, cy, xmin, xmax, ymin, ymax;
  logic [1:0]  gt_r, lt_r;   // sign flags of e0 (bit 0) and e1 (bit 1)

  function automatic logic [10:0] min3(input logic [10:0] a, b, c);
    logic [10:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [10:0] max3(input logic [10:0] a, b, c);
    logic [10:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Shared evaluator operand select: p, a, b for E(p;a,b)
  logic [10:0] px, py, ax, ay, bx, by;
  always_comb begin
    px = cx; py = cy;
    ax = x3; ay = y3;
    bx = x1; by = y1;
    unique case (state)
      SETUP: begin px = x1; py = y1; ax = x2; ay = y2; bx = x3; by = y3; end
      EVAL0: begin ax = x1; ay = y1; bx = x2; by = y2; end
      EVAL1: begin ax = x2; ay = y2; bx = x3; by = y3; end
      default: ;
    endcase
  end

  // Edge function: 12-bit signed differences, 24-bit products, 25-bit result
  logic signed [11:0] dpx, day, dax, dpy;
  logic signed [23:0] m0, m1;
  logic signed [24:0] e_val;
  logic               e_gt, e_lt;
  always_comb begin
    dpx   = $signed({1'b0, px}) - $signed({1'b0, bx});
    day   = $signed({1'b0, ay}) - $signed({1'b0, by});
    dax   = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dpy   = $signed({1'b0, py}) - $signed({1'b0, by});
    m0    = dpx * day;
    m1    = dax * dpy;
    e_val = $signed({m0[23], m0}) - $signed({m1[23], m1});
    e_lt  = e_val[24];
    e_gt  = !e_val[24] && (e_val != 25'sd0);
  end

  // Bounding box from the latched vertices, upper bound clamped to the screen
  logic [10:0] xmin_c, xmax_c, ymin_c, ymax_c, xmx, ymx;
  logic        skip;
  always_comb begin
    xmin_c = min3(x1, x2, x3);
    ymin_c = min3(y1, y2, y3);
    xmx    = max3(x1, x2, x3);
    ymx    = max3(y1, y2, y3);
    xmax_c = (xmx > XLIM) ? XLIM : xmx;
    ymax_c = (ymx > YLIM) ? YLIM : ymx;
    skip   = (e_val == 25'sd0) || (xmin_c > XLIM) || (ymin_c > YLIM);
  end

  // Coverage uses e0/e1 flags from earlier cycles plus e2 live in EVAL2
  logic [2:0] gt_all, lt_all;
  logic       covered, last_px;
  always_comb begin
    gt_all  = {e_gt, gt_r};
    lt_all  = {e_lt, lt_r};
    covered = EDGE_INCL ? ((lt_all == 3'b000) || (gt_all == 3'b000))
                        : ((gt_all == 3'b111) || (lt_all == 3'b111));
    last_px = (cx >= xmax) && (cy >= ymax);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = SETUP;
      SETUP:   state_nx = skip ? DONE : EVAL0;
      EVAL0:   state_nx = EVAL1;
      EVAL1:   state_nx = EVAL2;
      EVAL2:   state_nx = covered ? EMIT : STEP;
      EMIT:    if (out_ready) state_nx = STEP;
      STEP:    state_nx = last_px ? DONE : EVAL0;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Vertex latch, bbox, scan counters and sign flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {x1, y1, x2, y2, x3, y3} <= '0;
      {cx, cy, xmin, xmax, ymin, ymax} <= '0;
      gt_r <= '0;
      lt_r <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) {x1, y1, x2, y2, x3, y3} <= {v1x, v1y, v2x, v2y, v3x, v3y};
        SETUP: begin
          xmin <= xmin_c; xmax <= xmax_c;
          ymin <= ymin_c; ymax <= ymax_c;
          cx   <= xmin_c; cy   <= ymin_c;
        end
        EVAL0: begin gt_r[0] <= e_gt; lt_r[0] <= e_lt; end
        EVAL1: begin gt_r[1] <= e_gt; lt_r[1] <= e_lt; end
        STEP: begin
          if (cx < xmax) cx <= 11'(cx + 11'd1);
          else if (cy < ymax) begin
            cx <= xmin;
            cy <= 11'(cy + 11'd1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRI_SCAN_STATS_EN
  // Per-triangle counters: cleared on accept, held after DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tested  <= '0;
      stat_emitted <= '0;
    end else if (state == IDLE && in_valid) begin
      stat_tested  <= '0;
      stat_emitted <= '0;
    end else begin
      if (state == STEP) stat_tested <= stat_tested + 22'd1;
      if (state == EMIT && out_ready) stat_emitted <= stat_emitted + 22'd1;
    end
  end
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == EMIT);
  assign out_x     = out_valid ? cx : 11'd0;
  assign out_y     = out_valid ? cy : 11'd0;

endmodule

// File: tb/tb_triangle_scan_ctrl.sv
// Bench for triangle_scan_ctrl: per-scenario tasks against a pixel-list model.
module tb_triangle_scan_ctrl;

  localparam int W = 640;
  localparam int H = 480;
  localparam bit INCL = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [10:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic        out_valid, out_ready;
  logic [10:0] out_x, out_y;
  logic        busy, done;
`ifdef TRI_SCAN_STATS_EN
  logic [21:0] stat_tested, stat_emitted;
`endif

  triangle_scan_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done)
`ifdef TRI_SCAN_STATS_EN
    , .stat_tested(stat_tested), .stat_emitted(stat_emitted)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [21:0] got_q[$], exp_q[$];   // {x, y}
  int exp_tested;
  int cyc, done_cnt, done_cyc, hold_viol, oob, stall_seen;
  bit prev_stall;
  logic [10:0] prev_x, prev_y;

  function automatic int edgef(int px, int py, int ax, int ay, int bx, int by);
    return (px - bx) * (ay - by) - (ax - bx) * (py - by);
  endfunction

  // Expected pixel list straight from the coverage rule over the clamped box
  task automatic model(input int x1, y1, x2, y2, x3, y3);
    int xmin, xmax, ymin, ymax, e0, e1, e2;
    bit cov;
    exp_q.delete();
    exp_tested = 0;
    xmin = x1 < x2 ? x1 : x2; xmin = x3 < xmin ? x3 : xmin;
    ymin = y1 < y2 ? y1 : y2; ymin = y3 < ymin ? y3 : ymin;
    xmax = x1 > x2 ? x1 : x2; xmax = x3 > xmax ? x3 : xmax;
    ymax = y1 > y2 ? y1 : y2; ymax = y3 > ymax ? y3 : ymax;
    if (xmax > W - 1) xmax = W - 1;
    if (ymax > H - 1) ymax = H - 1;
    if (edgef(x1, y1, x2, y2, x3, y3) == 0 || xmin > W - 1 || ymin > H - 1) return;
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++) begin
        exp_tested++;
        e0 = edgef(x, y, x1, y1, x2, y2);
        e1 = edgef(x, y, x2, y2, x3, y3);
        e2 = edgef(x, y, x3, y3, x1, y1);
        if (INCL) cov = (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
        else      cov = (e0 > 0 && e1 > 0 && e2 > 0) || (e0 < 0 && e1 < 0 && e2 < 0);
        if (cov) exp_q.push_back({11'(x), 11'(y)});
      end
  endtask

  function automatic int first_diff();
    int n;
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // One clock: drive after the rising edge, sample on the falling edge
  task automatic tick(input int mode, input bit junk);
    @(posedge clk); #1;
    if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    if (mode == 2) out_ready = (stall_seen >= 5);
    if (junk) begin
      in_valid = 1'($urandom);
      {v1x, v1y, v2x, v2y, v3x, v3y} = {$urandom, $urandom, $urandom};
    end
    @(negedge clk);
    cyc++;
    if (prev_stall && (out_valid !== 1'b1 || out_x !== prev_x || out_y !== prev_y)) hold_viol++;
    prev_stall = out_valid && !out_ready;
    prev_x = out_x; prev_y = out_y;
    if (out_valid && !out_ready) stall_seen++;
    if (out_valid && out_ready) begin
      got_q.push_back({out_x, out_y});
      if (out_x > 11'(W - 1) || out_y > 11'(H - 1)) oob++;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  // Offer one triangle, then clock until done or the cycle limit
  task automatic run_tri(input int x1, y1, x2, y2, x3, y3, input int mode, input int limit);
    model(x1, y1, x2, y2, x3, y3);
    got_q.delete();
    cyc = 0; done_cnt = 0; done_cyc = -1; hold_viol = 0; oob = 0; stall_seen = 0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    {v1x, v1y, v2x, v2y, v3x, v3y} = {11'(x1), 11'(y1), 11'(x2), 11'(y2), 11'(x3), 11'(y3)};
    out_ready = (mode != 2);
    while (cyc < limit && done_cyc < 0) tick(mode, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    {v1x, v1y, v2x, v2y, v3x, v3y} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL reset_ctrl in_ready=%b busy=%b want 1/0", in_ready, busy); end
    tests++; if (out_valid !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL reset_out out_valid=%b done=%b want 0/0", out_valid, done); end
    tests++; if (out_x !== 11'd0 || out_y !== 11'd0) begin fails++;
      $display("FAIL reset_xy got (%0d,%0d) want (0,0)", out_x, out_y); end
    rst = 1'b0;
  endtask

  task automatic test_example();
    bit has99, has45;
    run_tri(4, 9, 9, 5, 12, 11, 0, 20000);
    has99 = 0; has45 = 0;
    foreach (got_q[i]) begin
      if (got_q[i] == {11'd9, 11'd9}) has99 = 1;
      if (got_q[i] == {11'd4, 11'd5}) has45 = 1;
    end
    tests++; if (has99 !== 1'b1 || has45 !== 1'b0) begin fails++;
      $display("FAIL example_pix has(9,9)=%b has(4,5)=%b want 1/0", has99, has45); end
    tests++; if (first_diff() != -1) begin fails++;
      $display("FAIL example_list diff at %0d got %0d pixels want %0d", first_diff(), got_q.size(), exp_q.size()); end
    tests++; if (done_cnt != 1) begin fails++;
      $display("FAIL example_done got %0d pulses want 1", done_cnt); end
`ifdef TRI_SCAN_STATS_EN
    tests++; if (stat_tested !== 22'd63 || stat_emitted !== 22'(exp_q.size())) begin fails++;
      $display("FAIL example_stats tested=%0d emitted=%0d want 63/%0d", stat_tested, stat_emitted, exp_q.size()); end
`endif
  endtask

  task automatic test_corner();
    logic [21:0] want[4];
    run_tri(0, 0, 3, 0, 0, 3, 1, 20000);
    want[0] = {11'd0, 11'd0}; want[1] = {11'd1, 11'd0};
    want[2] = {11'd2, 11'd0}; want[3] = {11'd3, 11'd0};
    tests++; if (got_q.size() != 10) begin fails++;
      $display("FAIL corner_count got %0d want 10", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== want[i]) begin fails++;
        $display("FAIL corner_order idx %0d got (%0d,%0d) want (%0d,%0d)", i,
                 got_q[i][21:11], got_q[i][10:0], want[i][21:11], want[i][10:0]); end
    end
    tests++; if (first_diff() != -1) begin fails++;
      $display("FAIL corner_list diff at %0d", first_diff()); end
  endtask

  task automatic test_degenerate();
    run_tri(0, 0, 5, 5, 10, 10, 0, 50);
    tests++; if (got_q.size() != 0 || done_cyc != 2) begin fails++;
      $display("FAIL degen pixels=%0d done_cycle=%0d want 0/2", got_q.size(), done_cyc); end
    tick(0, 1'b0);
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL degen_idle in_ready=%b busy=%b done=%b want 1/0/0", in_ready, busy, done); end
  endtask

  task automatic test_offscreen();
    run_tri(2040, 2040, 2047, 2040, 2040, 2047, 0, 50);
    tests++; if (got_q.size() != 0 || done_cnt != 1) begin fails++;
      $display("FAIL offscreen pixels=%0d done=%0d want 0/1", got_q.size(), done_cnt); end
    run_tri(630, 10, 660, 12, 635, 20, 1, 20000);
    tests++; if (oob != 0 || first_diff() != -1 || exp_q.size() == 0) begin fails++;
      $display("FAIL straddle oob=%0d diff=%0d got %0d want %0d", oob, first_diff(), got_q.size(), exp_q.size()); end
`ifdef TRI_SCAN_STATS_EN
    tests++; if (stat_tested !== 22'(exp_tested)) begin fails++;
      $display("FAIL straddle_stats tested=%0d want %0d", stat_tested, exp_tested); end
`endif
  endtask

  task automatic test_backpressure();
    run_tri(4, 9, 9, 5, 12, 11, 2, 20000);
    tests++; if (hold_viol != 0 || stall_seen != 5) begin fails++;
      $display("FAIL bp_hold violations=%0d stalls=%0d want 0/5", hold_viol, stall_seen); end
    tests++; if (first_diff() != -1) begin fails++;
      $display("FAIL bp_list diff at %0d got %0d want %0d", first_diff(), got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    run_tri(0, 0, 3, 0, 0, 3, 0, 13);   // stop in EVAL1 of the third pixel
    #1; rst = 1'b1; in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
                 out_x !== 11'd0 || out_y !== 11'd0) begin fails++;
      $display("FAIL rst_mid_async out_valid=%b in_ready=%b busy=%b done=%b xy=(%0d,%0d)",
               out_valid, in_ready, busy, done, out_x, out_y); end
    tests++; if (got_q.size() != 2 || done_cnt != 0) begin fails++;
      $display("FAIL rst_mid_prefix pixels=%0d done=%0d want 2/0", got_q.size(), done_cnt); end
    @(posedge clk); #2; rst = 1'b0;
    run_tri(2, 1, 14, 6, 5, 12, 1, 20000);
    tests++; if (first_diff() != -1 || done_cnt != 1) begin fails++;
      $display("FAIL rst_mid_rescan diff=%0d done=%0d", first_diff(), done_cnt); end
  endtask

  task automatic test_random();
    int c[6];
    for (int t = 0; t < 14; t++) begin
      for (int k = 0; k < 6; k++) begin
        if (t >= 10) c[k] = (k % 2 == 0) ? $urandom_range(625, 650) : $urandom_range(465, 490);
        else         c[k] = $urandom_range(0, 22);
      end
      run_tri(c[0], c[1], c[2], c[3], c[4], c[5], 1, 20000);
      tests++; if (first_diff() != -1 || done_cnt != 1 || oob != 0 || hold_viol != 0) begin fails++;
        $display("FAIL random_%0d tri (%0d,%0d)(%0d,%0d)(%0d,%0d) diff=%0d got %0d want %0d done=%0d",
                 t, c[0], c[1], c[2], c[3], c[4], c[5], first_diff(), got_q.size(), exp_q.size(), done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_example();
    test_corner();
    test_degenerate();
    test_offscreen();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
